// File: rtl/ascii_cmd_decoder_if.sv
// Byte-level link between a UART front end and the command decoder.
// The master side supplies received bytes and transmitter status; the slave side returns commands and acknowledges.
interface ascii_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [4:0] ascii_d;
    logic       ascii_up_down;
    logic       ascii_stopwatch_watch;
    logic       ascii_hm_sms;
    logic       ascii_watch_set;
    logic       ascii_humi_temp;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] drop_cnt;

    modport master (
        output rx_data, rx_done, tx_busy,
        input  ascii_d, ascii_up_down, ascii_stopwatch_watch, ascii_hm_sms,
               ascii_watch_set, ascii_humi_temp, tx_data, tx_start, drop_cnt
    );

    modport slave (
        input  rx_data, rx_done, tx_busy,
        output ascii_d, ascii_up_down, ascii_stopwatch_watch, ascii_hm_sms,
               ascii_watch_set, ascii_humi_temp, tx_data, tx_start, drop_cnt
    );
endinterface

// File: rtl/ascii_cmd_decoder.sv
// Turns received ASCII bytes into command pulses and mode toggles.
// Every byte is acknowledged back to the UART through a one-entry pending slot.
module ascii_cmd_decoder #(
    parameter bit ECHO_EN   = 1'b1,
    parameter bit CASE_FOLD = 1'b1
) (
    input logic               clk,
    input logic               reset,
    ascii_cmd_decoder_if.slave bus
);

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    tx_state_t  state;
    logic       rx_valid_q;
    logic [7:0] rx_byte_q;
    logic [7:0] folded;
    logic [4:0] pulse_vec;
    logic [4:0] toggle_vec;
    logic       clear_all;
    logic       known;
    logic [7:0] ack_byte;
    logic       send_now;
    logic [4:0] pulse_q;
    logic [4:0] levels;
    logic       pend_valid;
    logic [7:0] pend_byte;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic [7:0] drop_q;

    // Decode from the registered byte, so commands land one edge after sampling.
    always_comb begin
        folded     = rx_byte_q;
        pulse_vec  = '0;
        toggle_vec = '0;
        clear_all  = 1'b0;
        if (CASE_FOLD && (rx_byte_q >= 8'h41) && (rx_byte_q <= 8'h5A)) begin
            folded = rx_byte_q | 8'h20;
        end
        case (folded)
            8'h72:   pulse_vec  = 5'b00001;
            8'h63:   pulse_vec  = 5'b00010;
            8'h75:   pulse_vec  = 5'b00100;
            8'h64:   pulse_vec  = 5'b01000;
            8'h73:   pulse_vec  = 5'b10000;
            8'h30:   toggle_vec = 5'b00001;
            8'h31:   toggle_vec = 5'b00010;
            8'h32:   toggle_vec = 5'b00100;
            8'h33:   toggle_vec = 5'b01000;
            8'h34:   toggle_vec = 5'b10000;
            8'h78:   clear_all  = 1'b1;
            default: ;
        endcase
        known    = (|pulse_vec) | (|toggle_vec) | clear_all;
        ack_byte = known ? rx_byte_q : 8'h3F;
        send_now = (state == IDLE) && pend_valid && !bus.tx_busy;
    end

    // A send frees the pending slot on the same edge a new acknowledge may claim it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
            pulse_q    <= '0;
            levels     <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= 8'h00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            drop_q     <= 8'h00;
        end else begin
            rx_valid_q <= bus.rx_done;
            rx_byte_q  <= bus.rx_data;
            pulse_q    <= rx_valid_q ? pulse_vec : 5'b00000;
            if (rx_valid_q) begin
                levels <= clear_all ? 5'b00000 : (levels ^ toggle_vec);
            end

            tx_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_now) begin
                        state      <= SEND;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= pend_byte;
                    end
                end
                SEND: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (ECHO_EN && rx_valid_q) begin
                if (pend_valid && !send_now) begin
                    if (drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end else begin
                    pend_valid <= 1'b1;
                    pend_byte  <= ack_byte;
                end
            end else if (send_now) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.ascii_d               = pulse_q;
    assign bus.ascii_up_down         = levels[0];
    assign bus.ascii_stopwatch_watch = levels[1];
    assign bus.ascii_hm_sms          = levels[2];
    assign bus.ascii_watch_set       = levels[3];
    assign bus.ascii_humi_temp       = levels[4];
    assign bus.tx_start              = tx_start_q;
    assign bus.tx_data               = tx_data_q;
    assign bus.drop_cnt              = drop_q;

endmodule

// File: tb/tb_ascii_cmd_decoder.sv
// Drives three decoder variants (default, no case folding, no echo) with the same byte stream
// and checks each against a character-level model every cycle, plus pinned literal values.
module tb_ascii_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ascii_cmd_decoder_if bus0 ();
    ascii_cmd_decoder_if bus1 ();
    ascii_cmd_decoder_if bus2 ();

    assign bus0.rx_data = rx_data;
    assign bus0.rx_done = rx_done;
    assign bus0.tx_busy = tx_busy;
    assign bus1.rx_data = rx_data;
    assign bus1.rx_done = rx_done;
    assign bus1.tx_busy = tx_busy;
    assign bus2.rx_data = rx_data;
    assign bus2.rx_done = rx_done;
    assign bus2.tx_busy = tx_busy;

    ascii_cmd_decoder #(.ECHO_EN(1'b1), .CASE_FOLD(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    ascii_cmd_decoder #(.ECHO_EN(1'b1), .CASE_FOLD(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    ascii_cmd_decoder #(.ECHO_EN(1'b0), .CASE_FOLD(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    logic [4:0] act_d [3];
    logic [4:0] act_lv [3];
    logic       act_start [3];
    logic [7:0] act_txd [3];
    logic [7:0] act_drop [3];

    assign act_d[0]     = bus0.ascii_d;
    assign act_d[1]     = bus1.ascii_d;
    assign act_d[2]     = bus2.ascii_d;
    assign act_lv[0]    = {bus0.ascii_humi_temp, bus0.ascii_watch_set, bus0.ascii_hm_sms,
                           bus0.ascii_stopwatch_watch, bus0.ascii_up_down};
    assign act_lv[1]    = {bus1.ascii_humi_temp, bus1.ascii_watch_set, bus1.ascii_hm_sms,
                           bus1.ascii_stopwatch_watch, bus1.ascii_up_down};
    assign act_lv[2]    = {bus2.ascii_humi_temp, bus2.ascii_watch_set, bus2.ascii_hm_sms,
                           bus2.ascii_stopwatch_watch, bus2.ascii_up_down};
    assign act_start[0] = bus0.tx_start;
    assign act_start[1] = bus1.tx_start;
    assign act_start[2] = bus2.tx_start;
    assign act_txd[0]   = bus0.tx_data;
    assign act_txd[1]   = bus1.tx_data;
    assign act_txd[2]   = bus2.tx_data;
    assign act_drop[0]  = bus0.drop_cnt;
    assign act_drop[1]  = bus1.drop_cnt;
    assign act_drop[2]  = bus2.drop_cnt;

    // Model: what each variant must show, derived from the character tables.
    bit         echo_en_k [3] = '{1'b1, 1'b1, 1'b0};
    bit         fold_k [3]    = '{1'b1, 1'b0, 1'b1};
    logic [4:0] m_d [3];
    logic [4:0] m_lv [3];
    logic       m_start [3];
    logic [7:0] m_txd [3];
    int         m_drop [3];
    bit         m_pend_has [3];
    logic [7:0] m_pend_byte [3];
    bit         m_dv = 1'b0;
    logic [7:0] m_db = 8'h00;
    bit         model_ready = 1'b0;

    function automatic void model_decode(input logic [7:0] b, input bit fold,
                                         output logic [4:0] pulse, output logic [4:0] tog,
                                         output bit clr, output bit known);
        string      pulse_chars = "rcuds";
        string      toggle_chars = "01234";
        logic [7:0] c = b;
        if (fold && b >= 8'h41 && b <= 8'h5A) c = b + 8'd32;
        pulse = '0;
        tog   = '0;
        clr   = (c == 8'h78);
        for (int i = 0; i < 5; i++) begin
            if (c == pulse_chars[i]) pulse[i] = 1'b1;
            if (c == toggle_chars[i]) tog[i] = 1'b1;
        end
        known = clr || (pulse != 5'b0) || (tog != 5'b0);
    endfunction

    always @(posedge clk) begin
        logic [4:0] pulse;
        logic [4:0] tog;
        bit         clr;
        bit         known;
        bit         send;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_d[k] = '0; m_lv[k] = '0; m_start[k] = 1'b0; m_txd[k] = 8'h00;
                m_drop[k] = 0; m_pend_has[k] = 1'b0; m_pend_byte[k] = 8'h00;
            end
            m_dv = 1'b0;
            model_ready = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                model_decode(m_db, fold_k[k], pulse, tog, clr, known);
                m_d[k] = m_dv ? pulse : 5'b0;
                if (m_dv) m_lv[k] = clr ? 5'b0 : (m_lv[k] ^ tog);
                send = !m_start[k] && m_pend_has[k] && !tx_busy;
                if (send) begin
                    m_txd[k] = m_pend_byte[k];
                    m_pend_has[k] = 1'b0;
                end
                m_start[k] = send;
                if (m_dv && echo_en_k[k]) begin
                    if (m_pend_has[k]) begin
                        if (m_drop[k] < 255) m_drop[k] = m_drop[k] + 1;
                    end else begin
                        m_pend_has[k] = 1'b1;
                        m_pend_byte[k] = known ? m_db : 8'h3F;
                    end
                end
            end
            m_dv = rx_done;
            m_db = rx_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("dut%0d.ascii_d", k), 32'(act_d[k]), 32'(m_d[k]));
                checkOutput($sformatf("dut%0d.levels", k), 32'(act_lv[k]), 32'(m_lv[k]));
                checkOutput($sformatf("dut%0d.tx_start", k), 32'(act_start[k]), 32'(m_start[k]));
                checkOutput($sformatf("dut%0d.tx_data", k), 32'(act_txd[k]), 32'(m_txd[k]));
                checkOutput($sformatf("dut%0d.drop_cnt", k), 32'(act_drop[k]), m_drop[k]);
            end
        end
    end

    // Called on a falling edge; leaves rx_done low one cycle later unless the next call follows at once.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        idle(3);
        checkOutput("reset.ascii_d", 32'(bus0.ascii_d), 32'h0);
        checkOutput("reset.tx_data", 32'(bus0.tx_data), 32'h0);
        checkOutput("reset.drop_cnt", 32'(bus0.drop_cnt), 32'h0);
        reset = 1'b0;
        idle(2);

        $display("[TB] single run byte");
        applyStimulus(8'h72);
        idle(1);
        checkOutput("r.ascii_d", 32'(bus0.ascii_d), 32'h01);
        idle(1);
        checkOutput("r.tx_start", 32'(bus0.tx_start), 32'h1);
        checkOutput("r.tx_data", 32'(bus0.tx_data), 32'h72);
        checkOutput("r.pulse_gone", 32'(bus0.ascii_d), 32'h00);
        idle(3);

        $display("[TB] back-to-back toggles then fold clear");
        applyStimulus(8'h31);
        applyStimulus(8'h31);
        checkOutput("11.stopwatch_first", 32'(bus0.ascii_stopwatch_watch), 32'h1);
        applyStimulus(8'h34);
        checkOutput("11.stopwatch_second", 32'(bus0.ascii_stopwatch_watch), 32'h0);
        idle(1);
        checkOutput("114.levels", 32'(act_lv[0]), 32'h10);
        applyStimulus(8'h58);
        idle(2);
        checkOutput("X.levels", 32'(act_lv[0]), 32'h00);
        checkOutput("X.levels_nofold", 32'(act_lv[1]), 32'h10);
        idle(4);

        $display("[TB] unrecognized byte");
        pulseReset();
        applyStimulus(8'h33);
        idle(4);
        applyStimulus(8'h5A);
        idle(1);
        checkOutput("Z.ascii_d", 32'(bus0.ascii_d), 32'h00);
        checkOutput("Z.levels", 32'(act_lv[0]), 32'h08);
        idle(1);
        checkOutput("Z.tx_start", 32'(bus0.tx_start), 32'h1);
        checkOutput("Z.tx_data", 32'(bus0.tx_data), 32'h3F);
        idle(3);

        $display("[TB] busy transmitter drops second acknowledge");
        pulseReset();
        tx_busy = 1'b1;
        applyStimulus(8'h75);
        applyStimulus(8'h64);
        checkOutput("ud.ascii_d_u", 32'(bus0.ascii_d), 32'h04);
        idle(1);
        checkOutput("ud.ascii_d_d", 32'(bus0.ascii_d), 32'h08);
        checkOutput("ud.drop_cnt", 32'(bus0.drop_cnt), 32'h1);
        idle(2);
        checkOutput("ud.held", 32'(bus0.tx_start), 32'h0);
        tx_busy = 1'b0;
        idle(1);
        checkOutput("ud.tx_start", 32'(bus0.tx_start), 32'h1);
        checkOutput("ud.tx_data", 32'(bus0.tx_data), 32'h75);
        idle(1);
        checkOutput("ud.single", 32'(bus0.tx_start), 32'h0);
        idle(3);

        $display("[TB] upper case without folding");
        pulseReset();
        applyStimulus(8'h52);
        idle(1);
        checkOutput("R.nofold_ascii_d", 32'(bus1.ascii_d), 32'h00);
        checkOutput("R.fold_ascii_d", 32'(bus0.ascii_d), 32'h01);
        idle(1);
        checkOutput("R.nofold_tx_data", 32'(bus1.tx_data), 32'h3F);
        checkOutput("R.fold_tx_data", 32'(bus0.tx_data), 32'h52);
        checkOutput("R.noecho_tx_start", 32'(bus2.tx_start), 32'h0);
        idle(3);

        $display("[TB] reset with pending entry");
        tx_busy = 1'b1;
        applyStimulus(8'h30);
        applyStimulus(8'h32);
        applyStimulus(8'h33);
        idle(2);
        checkOutput("pre_reset.levels", 32'(act_lv[0]), 32'h0D);
        pulseReset();
        checkOutput("post_reset.levels", 32'(act_lv[0]), 32'h00);
        checkOutput("post_reset.drop_cnt", 32'(bus0.drop_cnt), 32'h0);
        checkOutput("post_reset.tx_data", 32'(bus0.tx_data), 32'h0);
        tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checkOutput("post_reset.no_tx_start", 32'(bus0.tx_start), 32'h0);
        end

        $display("[TB] reset beats rx_done");
        reset = 1'b1;
        applyStimulus(8'h73);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checkOutput("rst_rx.ascii_d", 32'(bus0.ascii_d), 32'h00);
            checkOutput("rst_rx.tx_start", 32'(bus0.tx_start), 32'h0);
        end

        $display("[TB] drop counter saturation");
        tx_busy = 1'b1;
        for (int i = 0; i < 300; i++) applyStimulus(8'h41);
        idle(2);
        checkOutput("sat.drop_cnt", 32'(bus0.drop_cnt), 32'd255);
        checkOutput("sat.noecho_drop_cnt", 32'(bus2.drop_cnt), 32'd0);
        tx_busy = 1'b0;
        idle(1);
        checkOutput("sat.tx_data", 32'(bus0.tx_data), 32'h3F);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
